// File: rtl/i_cache_pkg.sv
// i_cache_pkg: shared types and width helpers for the direct-mapped instruction cache.
// Contents: FSM state enum, derived-width functions (tag, in-line offset, beat index),
//           and the beat/word to line-bit mapping used by the line store.
package i_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RAM = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_FILL     = 2'd3
  } state_e;

  // Byte offset inside a line: byte-in-instruction bits plus instruction index bits.
  function automatic int offset_w(input int instr_w, input int instr_ix_w);
    return $clog2(instr_w / 8) + instr_ix_w;
  endfunction

  function automatic int tag_w(input int addr_w, input int line_ix_w,
                               input int instr_w, input int instr_ix_w);
    return addr_w - line_ix_w - offset_w(instr_w, instr_ix_w);
  endfunction

  function automatic int beat_ix_w(input int beat_count);
    return $clog2(beat_count);
  endfunction

  // Little-endian packing: slice ix of width w starts at bit ix*w of the line, so
  // the lower half of a beat holds the lower-address instruction.
  function automatic int slice_lsb(input int ix, input int w);
    return ix * w;
  endfunction

endpackage

// File: rtl/i_cache_line_store.sv
// i_cache_line_store: valid/tag/data arrays of the direct-mapped cache.
// Ports: clk_i/rst_i (rst clears valid bits only); beat write (wr_en_i, wr_line_i, wr_beat_i,
//        wr_dat_i); commit (commit_i, commit_tag_i) marks wr_line_i valid; async word read port.
module i_cache_line_store
  import i_cache_pkg::*;
#(
  parameter int LINE_IX_W = 1,
  parameter int TAG_W     = 6,
  parameter int WORD_W    = 32,
  parameter int WORD_IX_W = 3,
  parameter int BEAT_W    = 64,
  parameter int BEAT_IX_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [LINE_IX_W-1:0] wr_line_i,
  input  logic [BEAT_IX_W-1:0] wr_beat_i,
  input  logic [BEAT_W-1:0]    wr_dat_i,
  input  logic                 commit_i,
  input  logic [TAG_W-1:0]     commit_tag_i,
  input  logic [LINE_IX_W-1:0] rd_line_i,
  input  logic [WORD_IX_W-1:0] rd_word_i,
  output logic                 rd_vld_o,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic [WORD_W-1:0]    rd_dat_o
);

  localparam int NLINES = 1 << LINE_IX_W;
  localparam int LINE_W = (1 << WORD_IX_W) * WORD_W;

  logic [NLINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [LINE_W-1:0] data_q [NLINES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (commit_i) begin
      valid_q[wr_line_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only trusted behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[wr_line_i][slice_lsb(int'(wr_beat_i), BEAT_W) +: BEAT_W] <= wr_dat_i;
    end
    if (commit_i) begin
      tag_q[wr_line_i] <= commit_tag_i;
    end
  end

  assign rd_vld_o = valid_q[rd_line_i];
  assign rd_tag_o = tag_q[rd_line_i];
  assign rd_dat_o = data_q[rd_line_i][slice_lsb(int'(rd_word_i), WORD_W) +: WORD_W];

endmodule

// File: rtl/i_cache.sv
// i_cache: read-only direct-mapped instruction cache; hit answers one cycle after enable,
//          miss refills the whole line with one BurstRAM read burst, then answers.
// Ports: fetch side (enable, address, instruction, data_ready, busy); BurstRAM side (br_*).
module i_cache
  import i_cache_pkg::*;
#(
  parameter int LINE_IX_BITWIDTH                = 1,
  parameter int ADDRESS_BITWIDTH                = 12,
  parameter int INSTRUCTION_BITWIDTH            = 32,
  parameter int INSTRUCTION_IX_IN_LINE_BITWIDTH = 3,
  parameter int RAM_DEPTH_BITWIDTH              = 4,
  parameter int RAM_BURST_DATA_BITWIDTH         = 64,
  parameter int RAM_BURST_DATA_COUNT            = 4
) (
  input  logic                                 clk,
  input  logic                                 clk_ram,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [ADDRESS_BITWIDTH-1:0]          address,
  output logic [INSTRUCTION_BITWIDTH-1:0]      instruction,
  output logic                                 data_ready,
  output logic                                 busy,
  output logic                                 br_cmd,
  output logic                                 br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                                 br_rd_data_valid,
  input  logic                                 br_busy
);

  localparam int IW        = INSTRUCTION_BITWIDTH;
  localparam int IIX_W     = INSTRUCTION_IX_IN_LINE_BITWIDTH;
  localparam int LIX_W     = LINE_IX_BITWIDTH;
  localparam int WORD_SH   = $clog2(IW / 8);
  localparam int OFFSET_W  = offset_w(IW, IIX_W);
  localparam int TAG_W     = tag_w(ADDRESS_BITWIDTH, LIX_W, IW, IIX_W);
  localparam int BEAT_IX_W = beat_ix_w(RAM_BURST_DATA_COUNT);
  localparam int BEAT_SH   = $clog2(RAM_BURST_DATA_BITWIDTH / 8);

  state_e                      state_q, state_d;
  logic [ADDRESS_BITWIDTH-1:0] addr_q, addr_d;
  logic [BEAT_IX_W:0]          beat_cnt_q, beat_cnt_d;  // one extra bit: value COUNT means line complete
  logic [IW-1:0]               instr_q, instr_d;
  logic                        drdy_q, drdy_d;
  logic                        busy_q, busy_d;

  logic                        wr_en, commit;
  logic [LIX_W-1:0]            rd_line;
  logic [IIX_W-1:0]            rd_word;
  logic                        rd_vld;
  logic [TAG_W-1:0]            rd_tag;
  logic [IW-1:0]               rd_dat;
  logic                        hit;

  // Field split of the incoming request and of the latched one.
  logic [LIX_W-1:0] req_line, q_line;
  logic [IIX_W-1:0] req_word, q_word;
  logic [TAG_W-1:0] req_tag, q_tag;

  assign req_line = address[OFFSET_W +: LIX_W];
  assign req_word = address[WORD_SH +: IIX_W];
  assign req_tag  = address[ADDRESS_BITWIDTH-1 -: TAG_W];
  assign q_line   = addr_q[OFFSET_W +: LIX_W];
  assign q_word   = addr_q[WORD_SH +: IIX_W];
  assign q_tag    = addr_q[ADDRESS_BITWIDTH-1 -: TAG_W];

  // In IDLE the lookup runs on the live address so a hit answers at the accepting edge;
  // otherwise it serves the latched request once the refill completes.
  assign rd_line = (state_q == ST_IDLE) ? req_line : q_line;
  assign rd_word = (state_q == ST_IDLE) ? req_word : q_word;
  assign hit     = rd_vld && (rd_tag == req_tag);

  i_cache_line_store #(
    .LINE_IX_W (LIX_W),
    .TAG_W     (TAG_W),
    .WORD_W    (IW),
    .WORD_IX_W (IIX_W),
    .BEAT_W    (RAM_BURST_DATA_BITWIDTH),
    .BEAT_IX_W (BEAT_IX_W)
  ) u_store (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_en_i      (wr_en),
    .wr_line_i    (q_line),
    .wr_beat_i    (beat_cnt_q[BEAT_IX_W-1:0]),
    .wr_dat_i     (br_rd_data),
    .commit_i     (commit),
    .commit_tag_i (q_tag),
    .rd_line_i    (rd_line),
    .rd_word_i    (rd_word),
    .rd_vld_o     (rd_vld),
    .rd_tag_o     (rd_tag),
    .rd_dat_o     (rd_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      instr_q    <= '0;
      drdy_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      instr_q    <= instr_d;
      drdy_q     <= drdy_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    instr_d    = instr_q;
    drdy_d     = drdy_q;
    busy_d     = busy_q;
    br_cmd_en  = 1'b0;
    wr_en      = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          addr_d = address;
          if (hit) begin
            instr_d = rd_dat;
            drdy_d  = 1'b1;
          end else begin
            drdy_d     = 1'b0;
            busy_d     = 1'b1;
            beat_cnt_d = '0;
            state_d    = ST_WAIT_RAM;
          end
        end
      end
      ST_WAIT_RAM: begin
        if (!br_busy) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        br_cmd_en = 1'b1;
        state_d   = ST_FILL;
      end
      ST_FILL: begin
        if (int'(beat_cnt_q) == RAM_BURST_DATA_COUNT) begin
          // Line committed on the previous edge; read the requested word back out.
          instr_d = rd_dat;
          drdy_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (br_rd_data_valid) begin
          wr_en      = 1'b1;
          commit     = (int'(beat_cnt_q) == RAM_BURST_DATA_COUNT - 1);
          beat_cnt_d = beat_cnt_q + {{BEAT_IX_W{1'b0}}, 1'b1};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst start: byte address in beat units, aligned down to a whole line.
  assign br_addr      = {addr_q[BEAT_SH + BEAT_IX_W +: RAM_DEPTH_BITWIDTH - BEAT_IX_W], {BEAT_IX_W{1'b0}}};
  assign br_cmd       = 1'b0;
  assign br_wr_data   = '0;
  assign br_data_mask = '0;
  assign instruction  = instr_q;
  assign data_ready   = drdy_q;
  assign busy         = busy_q;

  // clk_ram shares the clk net; byte-in-instruction bits never select anything.
  logic unused_bits;
  assign unused_bits = &{1'b0, clk_ram, address[WORD_SH-1:0], addr_q[WORD_SH-1:0]};

endmodule

// File: tb/tb_i_cache.sv
module tb_i_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [11:0] address;
  logic [31:0] instruction;
  logic        data_ready;
  logic        busy;
  logic        br_cmd;
  logic        br_cmd_en;
  logic [3:0]  br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data;
  logic        br_rd_data_valid;
  logic        br_busy;

  always #5 clk = ~clk;

  i_cache dut (
    .clk              (clk),
    .clk_ram          (clk),
    .rst              (rst),
    .enable           (enable),
    .address          (address),
    .instruction      (instruction),
    .data_ready       (data_ready),
    .busy             (busy),
    .br_cmd           (br_cmd),
    .br_cmd_en        (br_cmd_en),
    .br_addr          (br_addr),
    .br_wr_data       (br_wr_data),
    .br_data_mask     (br_data_mask),
    .br_rd_data       (br_rd_data),
    .br_rd_data_valid (br_rd_data_valid),
    .br_busy          (br_busy)
  );

  // Reference model: BurstRAM contents plus per-line valid/tag of the cache.
  logic [63:0] ram [16];
  bit          mvalid [2];
  int          mtag   [2];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 8-byte beats, 32-byte lines, 16-beat RAM: byte address a lives in beat (a/8) mod 16.
  function automatic int beat_of(input logic [11:0] a);
    return (int'(a) / 8) % 16;
  endfunction

  function automatic int line_base(input logic [11:0] a);
    return beat_of(a) - (beat_of(a) % 4);
  endfunction

  function automatic logic [31:0] exp_word(input logic [11:0] a);
    logic [63:0] b;
    b = ram[beat_of(a)];
    return a[2] ? b[63:32] : b[31:0];
  endfunction

  function automatic int line_of(input logic [11:0] a);
    return (int'(a) / 32) % 2;
  endfunction

  function automatic int tag_of(input logic [11:0] a);
    return int'(a) / 64;
  endfunction

  task automatic deliver(input int base, input int first, input int cnt);
    for (int k = first; k < first + cnt; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      br_rd_data       = ram[base + k];
      br_rd_data_valid = 1'b1;
      tick();
      br_rd_data_valid = 1'b0;
      br_rd_data       = {$urandom, $urandom};
    end
  endtask

  // Finishes a miss already accepted by the DUT: command, burst, response.
  task automatic miss_tail(input logic [11:0] a);
    int n;
    n = 0;
    while (!br_cmd_en && n < 20) begin
      tick();
      n++;
    end
    enable = 1'b0;
    chk("cmd_seen", br_cmd_en, 1);
    chk("br_addr", br_addr, line_base(a));
    // A stray valid beat while the command is on the bus must be ignored.
    br_rd_data_valid = 1'b1;
    br_rd_data       = {$urandom, $urandom};
    tick();
    br_rd_data_valid = 1'b0;
    chk("cmd_once", br_cmd_en, 0);
    deliver(line_base(a), 0, 4);
    n = 0;
    while (!data_ready && n < 10) begin
      tick();
      n++;
    end
    chk("fill_ready", data_ready, 1);
    chk("fill_instr", instruction, exp_word(a));
    chk("fill_busy", busy, 0);
    mvalid[line_of(a)] = 1'b1;
    mtag[line_of(a)]   = tag_of(a);
  endtask

  task automatic fetch(input logic [11:0] a);
    bit hit;
    hit = mvalid[line_of(a)] && (mtag[line_of(a)] == tag_of(a));
    enable  = 1'b1;
    address = a;
    tick();
    enable = 1'b0;
    if (hit) begin
      chk("hit_ready", data_ready, 1);
      chk("hit_instr", instruction, exp_word(a));
      chk("hit_busy", busy, 0);
      chk("hit_no_cmd", br_cmd_en, 0);
    end else begin
      chk("miss_busy", busy, 1);
      chk("miss_ready", data_ready, 0);
      // Requests while busy are dropped, not queued.
      enable  = 1'b1;
      address = a ^ 12'h840;
      miss_tail(a);
    end
  endtask

  task automatic clear_model();
    mvalid[0] = 1'b0;
    mvalid[1] = 1'b0;
  endtask

  initial begin
    int n;
    logic [11:0] ra;
    ram[0] = 64'h11111111_00000000;
    ram[1] = 64'h33333333_22222222;
    ram[2] = 64'h55555555_44444444;
    ram[3] = 64'h77777777_66666666;
    for (int i = 4; i < 16; i++) ram[i] = {$urandom, $urandom};
    clear_model();
    rst = 1'b1; enable = 1'b0; address = '0;
    br_rd_data = '0; br_rd_data_valid = 1'b0; br_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_ready", data_ready, 0);
    chk("rst_cmd_en", br_cmd_en, 0);
    chk("rst_instr", instruction, 0);
    chk("br_cmd", br_cmd, 0);
    chk("br_wr_data", br_wr_data, 0);
    chk("br_data_mask", br_data_mask, 0);

    // Controller busy for 3 cycles: no command until it frees up.
    br_busy = 1'b1;
    enable  = 1'b1;
    address = 12'h000;
    tick();
    enable = 1'b0;
    chk("wait_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      chk("cmd_held", br_cmd_en, 0);
      tick();
    end
    br_busy = 1'b0;
    miss_tail(12'h000);

    // Reset invalidates, so the next fetch is a cold miss.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    chk("rst2_ready", data_ready, 0);

    fetch(12'h008);
    chk("cold_word", instruction, 32'h22222222);
    fetch(12'h01C);
    chk("hit_word", instruction, 32'h77777777);
    tick();
    tick();
    chk("hold_ready", data_ready, 1);
    chk("hold_instr", instruction, 32'h77777777);

    fetch(12'h040);
    fetch(12'h000);
    fetch(12'h020);
    fetch(12'h040);
    fetch(12'h020);
    fetch(12'h040);

    // Reset after two beats of a fill; the leftover beats must have no effect.
    enable  = 1'b1;
    address = 12'h100;
    tick();
    enable = 1'b0;
    chk("abort_busy", busy, 1);
    n = 0;
    while (!br_cmd_en && n < 20) begin
      tick();
      n++;
    end
    chk("abort_cmd", br_cmd_en, 1);
    tick();
    deliver(line_base(12'h100), 0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    chk("abort_rst_busy", busy, 0);
    chk("abort_rst_ready", data_ready, 0);
    deliver(line_base(12'h100), 2, 2);
    chk("abort_late_busy", busy, 0);
    chk("abort_late_ready", data_ready, 0);
    chk("abort_late_cmd", br_cmd_en, 0);
    fetch(12'h100);

    // Random fetches over a small tag/line space so hits and conflicts both occur.
    for (int i = 0; i < 40; i++) begin
      ra = 12'($urandom_range(0, 4095)) & 12'h27F;
      fetch(ra);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
